// File: rtl/usr_sequencer_if.sv
// Port bundle between a command source and usr_sequencer: command and
// serial-fill handshakes, shift-register control pins and observation outputs.
interface usr_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CW-1:0]    cmd_count;
  logic             sin_valid;
  logic             sin_data;
  logic             sin_ready;
  logic [1:0]       usr_sel;
  logic [WIDTH-1:0] usr_inp;
  logic             usr_serial_in;
  logic [WIDTH-1:0] shadow_q;
  logic             sout_valid;
  logic             sout_data;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, sin_valid, sin_data,
    input  cmd_ready, sin_ready, usr_sel, usr_inp, usr_serial_in,
           shadow_q, sout_valid, sout_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, sin_valid, sin_data,
    output cmd_ready, sin_ready, usr_sel, usr_inp, usr_serial_in,
           shadow_q, sout_valid, sout_data, busy, done
  );
endinterface

// File: rtl/usr_sequencer.sv
// Command sequencer for the 4-bit universal shift register: runs LOAD and
// multi-bit SHIFT commands, pulls fill bits, tracks contents and emits shifted-out bits.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input logic           clk,
  input logic           reset,
  usr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  state_t           state, state_next;
  op_t              op_q, cmd_op;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] shadow;
  logic             done_q, sout_valid_q, sout_data_q;

  logic             cmd_ready, sin_ready, serial_in;
  logic [1:0]       sel;
  logic [WIDTH-1:0] inp;
  logic             accept, shift_fire;

  assign cmd_op     = op_t'(bus.cmd_op);
  assign accept     = bus.cmd_valid && cmd_ready;
  assign shift_fire = sin_ready && bus.sin_valid;

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sel        = 2'b00;
    inp        = '0;
    serial_in  = 1'b0;
    cmd_ready  = 1'b0;
    sin_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (cmd_op == OP_LOAD)
            state_next = LOAD;
          else if ((cmd_op == OP_SHL || cmd_op == OP_SHR) && bus.cmd_count != '0)
            state_next = SHIFT;
          else
            state_next = DONE;
        end
      end
      LOAD: begin
        sel        = 2'b11;
        inp        = data_q;
        state_next = DONE;
      end
      SHIFT: begin
        sin_ready = 1'b1;
        // Without a fill bit the register is told to hold (stall).
        if (bus.sin_valid) begin
          sel       = op_q;
          serial_in = bus.sin_data;
          if (rem == CW'(1))
            state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The attached register resets on the same cycle; keep the port quiet.
    if (reset) begin
      state_next = IDLE;
      sel        = 2'b00;
      inp        = '0;
      serial_in  = 1'b0;
      cmd_ready  = 1'b0;
      sin_ready  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shadow       <= '0;
      rem          <= '0;
      done_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_data_q  <= 1'b0;
    end else begin
      state        <= state_next;
      done_q       <= (state_next == DONE);
      sout_valid_q <= shift_fire;
      if (accept)
        rem <= bus.cmd_count;
      else if (shift_fire)
        rem <= rem - CW'(1);
      if (state == LOAD)
        shadow <= data_q;
      else if (shift_fire) begin
        if (op_q == OP_SHL)
          shadow <= {shadow[WIDTH-2:0], bus.sin_data};
        else
          shadow <= {bus.sin_data, shadow[WIDTH-1:1]};
      end
      if (shift_fire)
        sout_data_q <= (op_q == OP_SHL) ? shadow[WIDTH-1] : shadow[0];
    end
  end

  // NOTE: the latched command is only read after an accept writes it, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      data_q <= bus.cmd_data;
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.sin_ready     = sin_ready;
  assign bus.usr_sel       = sel;
  assign bus.usr_inp       = inp;
  assign bus.usr_serial_in = serial_in;
  assign bus.shadow_q      = shadow;
  assign bus.sout_valid    = sout_valid_q;
  assign bus.sout_data     = sout_data_q;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Cycle-by-cycle directed vectors for usr_sequencer, a model of the attached
// shift register driven from the DUT pins, and hand sequences for reset/back-to-back.
module tb_usr_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usr_sequencer_if #(.WIDTH(4), .CW(3)) bus ();
  usr_sequencer #(.WIDTH(4), .CW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // The real register the sequencer controls, fed only from its output pins.
  logic [3:0] model_q;
  always @(posedge clk) begin
    if (reset) model_q <= 4'h0;
    else case (bus.usr_sel)
      2'b01:   model_q <= {model_q[2:0], bus.usr_serial_in};
      2'b10:   model_q <= {bus.usr_serial_in, model_q[3:1]};
      2'b11:   model_q <= bus.usr_inp;
      default: model_q <= model_q;
    endcase
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        cv;
    logic [1:0]  op;
    logic [3:0]  data;
    logic [2:0]  cnt;
    logic        sv;
    logic        sd;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected-output word: cmd_ready, sin_ready, usr_sel, usr_inp, usr_serial_in,
  // busy, done, sout_valid, sout_data, shadow_q.
  function automatic logic [16:0] e(input logic crdy, input logic srdy, input logic [1:0] sel,
                                    input logic [3:0] inp, input logic ser, input logic bsy,
                                    input logic dn, input logic sov, input logic sod,
                                    input logic [3:0] shq);
    return {crdy, srdy, sel, inp, ser, bsy, dn, sov, sod, shq};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.cmd_ready, bus.sin_ready, bus.usr_sel, bus.usr_inp, bus.usr_serial_in,
            bus.busy, bus.done, bus.sout_valid, bus.sout_data, bus.shadow_q};
  endfunction

  task automatic add(input string name, input logic rst, input logic cv, input logic [1:0] op,
                     input logic [3:0] data, input logic [2:0] cnt, input logic sv,
                     input logic sd, input logic [16:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.cv = cv; v.op = op; v.data = data;
    v.cnt = cnt; v.sv = sv; v.sd = sd; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic cv, input logic [1:0] op,
                       input logic [3:0] data, input logic [2:0] cnt, input logic sv,
                       input logic sd);
    reset         = rst;
    bus.cmd_valid = cv;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.sin_valid = sv;
    bus.sin_data  = sd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_seen;

    //  name          rst cv op  data  cnt sv sd      crdy srdy sel inp ser bsy dn sov sod shq
    add("reset",       1, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
    add("load_acc",    0, 1, 3, 4'hA, 0, 0, 0, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
    add("load",        0, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 3, 4'hA, 0, 1, 0, 0, 0, 4'h0));
    add("load_done",   0, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 4'hA));
    add("shr_acc",     0, 1, 2, 4'h0, 2, 0, 0, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'hA));
    add("shr_1",       0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 2, 4'h0, 1, 1, 0, 0, 0, 4'hA));
    add("shr_2",       0, 0, 0, 4'h0, 0, 1, 0, e(0, 1, 2, 4'h0, 0, 1, 0, 1, 0, 4'hD));
    add("shr_done",    0, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 1, 1, 1, 1, 4'h6));
    add("shl_acc",     0, 1, 1, 4'h0, 3, 0, 0, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h6));
    add("shl_1",       0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 1, 4'h0, 1, 1, 0, 0, 1, 4'h6));
    add("shl_stall1",  0, 0, 0, 4'h0, 0, 0, 1, e(0, 1, 0, 4'h0, 0, 1, 0, 1, 0, 4'hD));
    add("shl_stall2",  0, 0, 0, 4'h0, 0, 0, 1, e(0, 1, 0, 4'h0, 0, 1, 0, 0, 0, 4'hD));
    add("shl_2",       0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 1, 4'h0, 1, 1, 0, 0, 0, 4'hD));
    add("shl_3",       0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 1, 4'h0, 1, 1, 0, 1, 1, 4'hB));
    add("shl_done",    0, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 1, 1, 1, 1, 4'h7));
    add("nop_acc",     0, 1, 0, 4'hF, 3, 1, 1, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h7));
    add("nop_done",    0, 0, 0, 4'h0, 0, 1, 1, e(0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 4'h7));
    add("cnt0_acc",    0, 1, 2, 4'h0, 0, 1, 1, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h7));
    add("cnt0_done",   0, 0, 0, 4'h0, 0, 1, 1, e(0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 4'h7));
    add("long_acc",    0, 1, 1, 4'h0, 5, 0, 0, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h7));
    add("long_1",      0, 0, 0, 4'h0, 0, 1, 0, e(0, 1, 1, 4'h0, 0, 1, 0, 0, 1, 4'h7));
    add("long_2",      0, 0, 0, 4'h0, 0, 1, 0, e(0, 1, 1, 4'h0, 0, 1, 0, 1, 0, 4'hE));
    add("long_3",      0, 0, 0, 4'h0, 0, 1, 0, e(0, 1, 1, 4'h0, 0, 1, 0, 1, 1, 4'hC));
    add("long_4",      0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 1, 4'h0, 1, 1, 0, 1, 1, 4'h8));
    add("long_5",      0, 0, 0, 4'h0, 0, 1, 1, e(0, 1, 1, 4'h0, 1, 1, 0, 1, 1, 4'h1));
    add("long_done",   0, 0, 0, 4'h0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 1, 1, 1, 0, 4'h3));
    add("idle_after",  0, 0, 0, 4'h0, 0, 0, 0, e(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h3));

    drive(1, 0, 0, 4'h0, 0, 0, 0);
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].data, tbl[i].cnt, tbl[i].sv, tbl[i].sd);
      @(negedge clk);
      check(tbl[i].name, 32'(observed()), 32'(tbl[i].exp));
      check({tbl[i].name, "_reg"}, 32'(bus.shadow_q), 32'(model_q));
      next_cycle();
    end

    // Reset in the second shift cycle of SHR count 4.
    drive(0, 1, 2, 4'h0, 4, 1, 1);
    @(negedge clk); check("rst_acc_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle();
    drive(0, 0, 0, 4'h0, 0, 1, 1);
    @(negedge clk); check("rst_shift1_sel", 32'(bus.usr_sel), 32'd2);
    next_cycle();
    drive(1, 0, 0, 4'h0, 0, 1, 1);
    @(negedge clk);
    check("rst_cycle_ready", 32'({bus.cmd_ready, bus.sin_ready, bus.usr_sel}), 32'd0);
    next_cycle();
    drive(0, 0, 0, 4'h0, 0, 1, 1);
    @(negedge clk);
    check("rst_after_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_after_shadow", 32'(bus.shadow_q), 32'h0);
    check("rst_after_sout", 32'({bus.sout_valid, bus.done, bus.busy}), 32'd0);
    check("rst_after_reg", 32'(bus.shadow_q), 32'(model_q));
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(0, 0, 0, 4'h0, 0, 0, 0);
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);
    next_cycle();

    // cmd_valid held high across two queued commands: LOAD 5, then SHL 1 with sin 0.
    drive(0, 1, 3, 4'h5, 0, 1, 0);
    @(negedge clk); check("b2b_acc1_ready", 32'(bus.cmd_ready), 32'd1);
    next_cycle();
    drive(0, 1, 1, 4'h0, 1, 1, 0);
    @(negedge clk);
    check("b2b_load", 32'({bus.cmd_ready, bus.busy, bus.usr_sel, bus.usr_inp}), 32'({1'b0, 1'b1, 2'b11, 4'h5}));
    next_cycle();
    @(negedge clk);
    check("b2b_done1", 32'({bus.cmd_ready, bus.done, bus.shadow_q}), 32'({1'b0, 1'b1, 4'h5}));
    next_cycle();
    @(negedge clk); check("b2b_acc2_ready", 32'({bus.cmd_ready, bus.busy}), 32'({1'b1, 1'b0}));
    next_cycle();
    drive(0, 0, 0, 4'h0, 0, 1, 0);
    @(negedge clk);
    check("b2b_shift", 32'({bus.cmd_ready, bus.usr_sel, bus.usr_serial_in}), 32'({1'b0, 2'b01, 1'b0}));
    next_cycle();
    drive(0, 0, 0, 4'h0, 0, 0, 0);
    @(negedge clk);
    check("b2b_done2", 32'({bus.done, bus.sout_valid, bus.sout_data, bus.shadow_q}),
          32'({1'b1, 1'b1, 1'b0, 4'hA}));
    check("b2b_reg", 32'(bus.shadow_q), 32'(model_q));
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usr_sequencer.md
# usr_sequencer

Command-driven controller that sequences the team's 4-bit universal shift register (hold / shift-left / shift-right / parallel-load, selected by a 2-bit `sel`). It accepts LOAD and multi-bit SHIFT commands over a valid/ready port, pulls serial fill bits from a stream port, and drives the register's `sel`, `inp` and `serial_in` pins. It also keeps a shadow copy of the register contents and emits each bit shifted out, so it works as a serializer/deserializer front end.

## Interface
- `WIDTH`, 4, register width; must match the attached shift register.
- `CW`, 3, width of shift count; must hold `WIDTH`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 NOP, 01 SHL, 10 SHR, 11 LOAD.
- `cmd_data` in WIDTH: parallel load value; LOAD only.
- `cmd_count` in CW: number of shifts; SHL/SHR only.
- `sin_valid` in 1: serial fill bit available.
- `sin_data` in 1: serial fill bit.
- `sin_ready` out 1: fill bit consumed when `sin_valid && sin_ready`.
- `usr_sel` out 2: to the register's `sel`: 00 hold, 01 shift-left (`serial_in` enters bit 0), 10 shift-right (`serial_in` enters bit WIDTH-1), 11 load.
- `usr_inp` out WIDTH: to the register's `inp`.
- `usr_serial_in` out 1: to the register's `serial_in`.
- `shadow_q` out WIDTH: expected register contents after the most recent edge.
- `sout_valid` out 1: one-cycle pulse; a bit left the register.
- `sout_data` out 1: the bit that left.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- FSM states are IDLE, LOAD, SHIFT and DONE.
- **IDLE**
  - `cmd_ready` = 1 and `usr_sel` = 00.
  - On accept, latch `op`, `data` and `count` into `rem`.
  - Next state: LOAD for op 11; SHIFT for op 01/10 with count ≠ 0; DONE for NOP or count = 0.
- **LOAD**
  - Lasts exactly one cycle.
  - Outputs: `usr_sel` = 11, `usr_inp` = latched data.
  - At the edge, `shadow_q` takes the latched data. Next state is DONE.
- **SHIFT**
  - `sin_ready` = 1.
  - If `sin_valid` = 1:
    - `usr_sel` = 01 (SHL) or 10 (SHR), and `usr_serial_in` = `sin_data`.
    - At the edge: `rem` decrements; `shadow_q` updates (SHL: {q[WIDTH-2:0], sin}; SHR: {sin, q[WIDTH-1:1]}).
    - `sout_data` takes q[WIDTH-1] (SHL) or q[0] (SHR), and `sout_valid` is set for the following cycle.
  - If `sin_valid` = 0: `usr_sel` = 00 (stall); `rem`, `shadow_q` and the register hold.
  - Go to DONE at the edge where `rem` goes 1→0.
- **DONE**
  - `done` = 1 and `cmd_ready` = 0 for one cycle, then IDLE.
- Output defaults when not specified above: `usr_sel` = 00, `usr_inp` = 0, `usr_serial_in` = 0, `sin_ready` = 0.
- `busy` = (state ≠ IDLE).
- `cmd_count` > WIDTH is legal: the block shifts that many times and emits every bit.
- NOP never touches the register; `usr_sel` stays 00 throughout.

## Timing
- **Reset values:** state IDLE; `shadow_q` = 0, `rem` = 0, `done` = 0, `sout_valid` = 0, `sout_data` = 0. During the reset cycle: `cmd_ready` = 0, `sin_ready` = 0, `usr_sel` = 00.
- **Reset mid-command:** the command is abandoned; no `done` pulse; `cmd_ready` = 1 in the first cycle after reset deasserts. The attached register resets to 0 on the same reset, so `shadow_q` stays consistent with it.
- **Combinational paths:**
  - `usr_sel`, `usr_inp`, `usr_serial_in`, `cmd_ready`, `sin_ready` and `busy` decode from state only.
  - `usr_serial_in` and the SHIFT-state `usr_sel` also depend on the `sin_valid`/`sin_data` inputs.
- **Registered outputs:** `done`, `sout_valid`, `sout_data`, `shadow_q`.
- **Latency, accept edge = cycle 0:**
  - NOP / count 0: `done` in cycle 1.
  - LOAD: `sel` = 11 in cycle 1; `done` in cycle 2.
  - SHIFT n with no stalls: shifts in cycles 1..n; `done` in cycle n+1.
  - Each stall cycle adds one cycle.
- **Throughput:** the earliest next accept is the cycle after DONE.
- **Timing of `sout_valid`:** it is asserted in the cycle after each shift edge; for the final shift, that cycle coincides with `done`.
- **Shadow tracking:** `shadow_q` equals the register's `out` at every cycle boundary.

## Test plan
- Reset, then LOAD `cmd_data` = 4'hA → `usr_sel` = 11 and `usr_inp` = A for exactly one cycle; `shadow_q` = 1010; `done` two cycles after accept; no `sout_valid`.
- From 1010: SHR count 2, `sin` 1 then 0 with no stalls →
  - `usr_sel` = 10 for two cycles.
  - `shadow_q` goes 1101 then 0110.
  - `sout_data` is 0 then 1, each with a `sout_valid` pulse.
  - `done` in cycle 3.
- From 0110: SHL count 3, `sin` = 1, with `sin_valid` low for two cycles between the first and second bit →
  - `usr_sel` = 00 during the stalls.
  - `shadow_q` goes 1101, then 1011, then 0111.
  - `sout` bits are 0, 1, 1.
  - `done` in cycle 6.
- NOP, and SHR with count 0 → `usr_sel` never leaves 00, `sin_ready` never asserts, `done` in cycle 1, `shadow_q` unchanged.
- Reset asserted in the second shift cycle of SHR count 4 → no `done`; `shadow_q` = 0; `sout_valid` = 0; `cmd_ready` = 1 the cycle after reset drops.
- `cmd_valid` held high continuously with two queued commands (LOAD 4'h5, then SHL count 1, `sin` = 0) →
  - `cmd_ready` is low while `busy`; the second command is accepted the cycle after `done`.
  - Final `shadow_q` = 1010, with `sout_data` = 0.
